// File: rtl/mem_resp_stall_if.sv
// Load/store request bus between the CPU memory stage (master) and the data memory (slave).
interface mem_resp_stall_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data_in;
    logic              rd;
    logic              wr;
    logic [DATA_W-1:0] data_out;
    logic              stall;
    logic              done;
    logic              err;

    modport master (
        output addr, data_in, rd, wr,
        input  data_out, stall, done, err
    );

    modport slave (
        input  addr, data_in, rd, wr,
        output data_out, stall, done, err
    );
endinterface

// File: rtl/mem_resp_stall.sv
// Multi-cycle data memory: accepts one load/store at a time, stalls the CPU while
// the access is in flight, then pulses done for one cycle after LATENCY cycles.
module mem_resp_stall #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int DEPTH_LOG2 = 8,
    parameter int LATENCY    = 4
) (
    input  logic            clk,
    input  logic            rst,
    mem_resp_stall_if.slave bus
);
    localparam int unsigned DEPTH    = 2 ** DEPTH_LOG2;
    localparam logic [3:0]  CNT_LOAD = 4'(LATENCY - 2);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]            state;
    logic [3:0]            count;
    logic                  op_wr;
    logic [DEPTH_LOG2-1:0] idx;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W-1:0]     dout;
    logic                  err_q;
    logic [DATA_W-1:0]     mem [DEPTH];

    logic req_any;
    logic req_ok;
    logic unused_addr;

    always_comb begin
        req_any = bus.rd | bus.wr;
        req_ok  = (bus.rd ^ bus.wr) & ~bus.addr[0];
    end

    // Address bits above the word index wrap silently.
    assign unused_addr = ^bus.addr[ADDR_W-1:DEPTH_LOG2+1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            count <= '0;
            op_wr <= 1'b0;
            idx   <= '0;
            wdata <= '0;
            dout  <= '0;
            err_q <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            err_q <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (req_ok) begin
                        op_wr <= bus.wr;
                        idx   <= bus.addr[DEPTH_LOG2:1];
                        wdata <= bus.data_in;
                        count <= CNT_LOAD;
                        state <= BUSY;
                    end else begin
                        err_q <= req_any;
                        state <= IDLE;
                    end
                end
                BUSY: begin
                    // Array access happens on the edge into DONE, so a write always
                    // lands before a back-to-back read accepted in the DONE cycle.
                    if (count == '0) begin
                        state <= DONE;
                        if (op_wr) begin
                            mem[idx] <= wdata;
                        end else begin
                            dout <= mem[idx];
                        end
                    end else begin
                        count <= count - 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.stall    = (state == BUSY);
    assign bus.done     = (state == DONE);
    assign bus.err      = err_q;
    assign bus.data_out = dout;

endmodule

// File: tb/tb_mem_resp_stall.sv
// Randomized bench for mem_resp_stall against a cycle-indexed transaction model.
module tb_mem_resp_stall;
    localparam int LAT = 4;

    logic clk = 1'b0;
    logic rst;

    mem_resp_stall_if #(.ADDR_W(16), .DATA_W(16)) bus ();

    mem_resp_stall #(
        .ADDR_W    (16),
        .DATA_W    (16),
        .DEPTH_LOG2(8),
        .LATENCY   (LAT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Model: the access accepted in cycle acc completes in cycle acc+LAT.
    logic [15:0] mmem [256];
    logic [15:0] exp_dout;
    int          cyc;
    int          acc;
    int          errc;
    logic        pend;
    logic        pend_wr;
    logic [7:0]  pend_idx;
    logic [15:0] pend_data;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 256; i++) mmem[i] = 16'h0000;
        exp_dout = 16'h0000;
        acc  = -100;
        errc = -100;
        pend = 1'b0;
    endtask

    task automatic step(input logic r, input logic w, input logic [15:0] a,
                        input logic [15:0] d, input logic rs);
        logic exp_stall;
        @(negedge clk);
        if (pend && cyc == acc + LAT) begin
            if (pend_wr) mmem[pend_idx] = pend_data;
            else         exp_dout = mmem[pend_idx];
            pend = 1'b0;
        end
        exp_stall = (cyc > acc) && (cyc < acc + LAT);
        check("stall",    32'(bus.stall),    32'(exp_stall));
        check("done",     32'(bus.done),     32'(cyc == acc + LAT));
        check("err",      32'(bus.err),      32'(cyc == errc + 1));
        check("data_out", 32'(bus.data_out), 32'(exp_dout));
        bus.rd = r; bus.wr = w; bus.addr = a; bus.data_in = d; rst = rs;
        if (rs) begin
            model_reset();
        end else if (!exp_stall) begin
            if ((r ^ w) && !a[0]) begin
                acc = cyc; pend = 1'b1; pend_wr = w; pend_idx = a[8:1]; pend_data = d;
            end else if (r | w) begin
                errc = cyc;
            end
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    endtask

    task automatic rd_req(input logic [15:0] a);
        step(1'b1, 1'b0, a, 16'($urandom), 1'b0);
    endtask

    task automatic wr_req(input logic [15:0] a, input logic [15:0] d);
        step(1'b0, 1'b1, a, d, 1'b0);
    endtask

    initial begin
        rst = 1'b1; bus.rd = 1'b0; bus.wr = 1'b0; bus.addr = '0; bus.data_in = '0;
        cyc = 0;
        model_reset();
        repeat (2) @(posedge clk);

        // Reset state, idle, read of a cleared word
        idle(5);
        rd_req(16'h0010); idle(LAT);

        // Write then read back, data_out held
        wr_req(16'h0024, 16'hBEEF); idle(LAT);
        rd_req(16'h0024); idle(LAT + 3);

        // Back-to-back read in the DONE cycle, with rd pulses during BUSY
        wr_req(16'h0002, 16'h1234);
        for (int i = 0; i < LAT - 1; i++) rd_req(16'h0040);
        rd_req(16'h0002);
        for (int i = 0; i < LAT - 1; i++) step(1'b1, 1'b1, 16'h0041, 16'hFFFF, 1'b0);
        idle(3);

        // Rejected requests, including one in a DONE cycle
        rd_req(16'h0005); idle(2);
        step(1'b1, 1'b1, 16'h0024, 16'h0000, 1'b0); idle(2);
        wr_req(16'h0024, 16'h7777); idle(LAT - 1);
        step(1'b0, 1'b1, 16'h0003, 16'h0000, 1'b0); idle(2);
        rd_req(16'h0024); idle(LAT + 1);

        // Reset mid-write
        wr_req(16'h0008, 16'hAAAA); idle(1);
        step(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
        idle(LAT + 1);
        rd_req(16'h0008); idle(LAT + 1);

        // Index wrap
        wr_req(16'h0202, 16'h5A5A); idle(LAT);
        rd_req(16'h0002); idle(LAT + 1);

        // Random traffic over a small address window to get plenty of hits
        for (int n = 0; n < 3000; n++) begin
            logic [15:0] a;
            logic        r, w, rs;
            a  = {7'($urandom), 5'd0, 3'($urandom_range(0, 7)), 1'b0};
            if ($urandom_range(0, 9) == 0) a[0] = 1'b1;
            r  = ($urandom_range(0, 2) == 0);
            w  = ($urandom_range(0, 3) == 0);
            rs = ($urandom_range(0, 299) == 0);
            step(r, w, a, 16'($urandom), rs);
        end
        idle(LAT + 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
